// File: rtl/round_pipe.sv
// Two-stage mantissa rounder with valid/ready flow control.
// S1 holds the round-up decision, S2 holds the rounded result.
package round_pkg;
    typedef enum logic [2:0] {
        IEEE_near = 3'd0,
        IEEE_zero = 3'd1,
        IEEE_pinf = 3'd2,
        IEEE_ninf = 3'd3,
        near_up   = 3'd4,
        away_zero = 3'd5
    } rnd_t;
endpackage

module round_pipe
    import round_pkg::*;
#(
    parameter int MANT_W = 24,
    parameter int TAIL_W = 24,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] in_mant,
    input  logic [TAIL_W-1:0] in_tail,
    input  logic              in_sign,
    input  rnd_t              in_rnd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W:0]   out_result,
    output logic              out_carry,
    output logic              out_inexact,
    output logic              out_sign,
    output logic [CNT_W-1:0]  inexact_cnt,
    input  logic              cnt_clr
);

    logic              s1_valid_q, s1_valid_d;
    logic [MANT_W-1:0] s1_mant_q, s1_mant_d;
    logic              s1_sign_q, s1_sign_d;
    logic              s1_inx_q, s1_inx_d;
    logic              s1_inc_q, s1_inc_d;
    logic              s2_valid_q, s2_valid_d;
    logic [MANT_W:0]   s2_res_q, s2_res_d;
    logic              s2_inx_q, s2_inx_d;
    logic              s2_sign_q, s2_sign_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic out_fire, s2_load, s1_adv, in_fire;
    logic guard, sticky, inexact, inc;

    always_comb begin
        out_fire = s2_valid_q & out_ready;
        s2_load  = !s2_valid_q | out_fire;
        s1_adv   = s1_valid_q & s2_load;
        in_ready = !s1_valid_q | s1_adv;
        in_fire  = in_valid & in_ready;
    end

    // Round-up decision; unknown codes fall back to round-to-nearest-even.
    always_comb begin
        guard   = in_tail[TAIL_W-1];
        sticky  = |in_tail[TAIL_W-2:0];
        inexact = guard | sticky;
        case (in_rnd)
            IEEE_zero: inc = 1'b0;
            IEEE_pinf: inc = !in_sign & inexact;
            IEEE_ninf: inc = in_sign & inexact;
            near_up:   inc = guard & (sticky | !in_sign);
            away_zero: inc = inexact;
            default:   inc = guard & (sticky | in_mant[0]);
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_mant_d  = s1_mant_q;
        s1_sign_d  = s1_sign_q;
        s1_inx_d   = s1_inx_q;
        s1_inc_d   = s1_inc_q;
        if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_mant_d  = in_mant;
            s1_sign_d  = in_sign;
            s1_inx_d   = inexact;
            s1_inc_d   = inc;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_res_d   = s2_res_q;
        s2_inx_d   = s2_inx_q;
        s2_sign_d  = s2_sign_q;
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
        end
        if (s1_adv) begin
            s2_res_d  = {1'b0, s1_mant_q} + {{MANT_W{1'b0}}, s1_inc_q};
            s2_inx_d  = s1_inx_q;
            s2_sign_d = s1_sign_q;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (out_fire && s2_inx_q && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_mant_q  <= '0;
            s1_sign_q  <= 1'b0;
            s1_inx_q   <= 1'b0;
            s1_inc_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
            s2_inx_q   <= 1'b0;
            s2_sign_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_mant_q  <= s1_mant_d;
            s1_sign_q  <= s1_sign_d;
            s1_inx_q   <= s1_inx_d;
            s1_inc_q   <= s1_inc_d;
            s2_valid_q <= s2_valid_d;
            s2_res_q   <= s2_res_d;
            s2_inx_q   <= s2_inx_d;
            s2_sign_q  <= s2_sign_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_valid   = s2_valid_q;
    assign out_result  = s2_res_q;
    assign out_carry   = s2_res_q[MANT_W];
    assign out_inexact = s2_inx_q;
    assign out_sign    = s2_sign_q;
    assign inexact_cnt = cnt_q;

endmodule

// File: tb/tb_round_pipe.sv
// Bench for round_pipe: vector table plus scoreboard, backpressure,
// counter saturation/clear and mid-stream reset sequences.
module tb_round_pipe;
    import round_pkg::*;

    localparam int MW = 24;
    localparam int TW = 24;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [MW-1:0] in_mant;
    logic [TW-1:0] in_tail;
    logic          in_sign;
    rnd_t          in_rnd;
    logic          out_valid;
    logic          out_ready;
    logic [MW:0]   out_result;
    logic          out_carry;
    logic          out_inexact;
    logic          out_sign;
    logic [CW-1:0] inexact_cnt;
    logic          cnt_clr;

    round_pipe #(.MANT_W(MW), .TAIL_W(TW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mant(in_mant), .in_tail(in_tail),
        .in_sign(in_sign), .in_rnd(in_rnd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_carry(out_carry),
        .out_inexact(out_inexact), .out_sign(out_sign),
        .inexact_cnt(inexact_cnt), .cnt_clr(cnt_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [MW:0] res;
        logic        inx;
        logic        sgn;
    } exp_t;

    typedef struct {
        logic [MW-1:0] mant;
        logic [TW-1:0] tail;
        logic          sign;
        logic [2:0]    rnd;
        logic [MW:0]   res;
        logic          inx;
    } vec_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   acc_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [MW-1:0] m,
                                   input logic [TW-1:0] t,
                                   input logic s, input logic [2:0] r);
        exp_t e;
        logic g, st, x, up;
        g  = t[TW-1];
        st = (t[TW-2:0] != '0);
        x  = g | st;
        case (r)
            3'd1:    up = 1'b0;
            3'd2:    up = x && !s;
            3'd3:    up = x && s;
            3'd4:    up = g && (st || !s);
            3'd5:    up = x;
            default: up = g && (st || m[0]);
        endcase
        e.res = {1'b0, m} + (up ? 25'd1 : 25'd0);
        e.inx = x;
        e.sgn = s;
        return e;
    endfunction

    task automatic send(input logic [MW-1:0] m, input logic [TW-1:0] t,
                        input logic s, input logic [2:0] r,
                        input exp_t e);
        bit done = 0;
        in_mant  = m;
        in_tail  = t;
        in_sign  = s;
        in_rnd   = rnd_t'(r);
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back(e);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (done) acc_cnt++;
        else chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_m(input logic [MW-1:0] m, input logic [TW-1:0] t,
                          input logic s, input logic [2:0] r);
        send(m, t, s, r, model(m, t, s, r));
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !out_valid) done = 1;
        end
        if (!done) chk("drain_timeout", 64'(q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        bit          held_v = 0;
        logic [MW:0] h_res;
        logic        h_inx, h_sgn;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (rst) begin
                held_v = 0;
            end else begin
                if (held_v && out_valid)
                    chk("stall_stable", {out_result, out_inexact, out_sign},
                        {h_res, h_inx, h_sgn});
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        chk("unexpected_out", {out_result, out_inexact}, 64'd0);
                        n_fail += (out_result == '0 && !out_inexact) ? 1 : 0;
                    end else begin
                        e = q.pop_front();
                        chk("result", {out_result, out_carry, out_inexact, out_sign},
                            {e.res, e.res[MW], e.inx, e.sgn});
                    end
                end
                held_v = out_valid && !out_ready;
                h_res  = out_result;
                h_inx  = out_inexact;
                h_sgn  = out_sign;
            end
        end
    endtask

    task automatic run_tests();
        vec_t vt[$];
        int   base;
        vt.push_back('{24'h800001, 24'h800000, 1'b0, 3'd0, 25'h0800002, 1'b1});
        vt.push_back('{24'h800001, 24'h800000, 1'b1, 3'd4, 25'h0800001, 1'b1});
        vt.push_back('{24'h800001, 24'h800000, 1'b0, 3'd4, 25'h0800002, 1'b1});
        vt.push_back('{24'h800000, 24'h800000, 1'b0, 3'd0, 25'h0800000, 1'b1});
        vt.push_back('{24'h800000, 24'hC00000, 1'b1, 3'd0, 25'h0800001, 1'b1});
        vt.push_back('{24'h123456, 24'h000001, 1'b1, 3'd1, 25'h0123456, 1'b1});
        vt.push_back('{24'h123456, 24'h000001, 1'b1, 3'd2, 25'h0123456, 1'b1});
        vt.push_back('{24'h123456, 24'h000001, 1'b1, 3'd3, 25'h0123457, 1'b1});
        vt.push_back('{24'h123456, 24'h000001, 1'b1, 3'd5, 25'h0123457, 1'b1});
        vt.push_back('{24'h123456, 24'h000001, 1'b0, 3'd2, 25'h0123457, 1'b1});
        vt.push_back('{24'h123456, 24'h000001, 1'b0, 3'd3, 25'h0123456, 1'b1});
        vt.push_back('{24'h123456, 24'h000000, 1'b1, 3'd5, 25'h0123456, 1'b0});
        vt.push_back('{24'h123457, 24'h000000, 1'b0, 3'd0, 25'h0123457, 1'b0});
        vt.push_back('{24'h123456, 24'h000000, 1'b1, 3'd3, 25'h0123456, 1'b0});
        vt.push_back('{24'hFFFFFF, 24'h000001, 1'b0, 3'd5, 25'h1000000, 1'b1});
        vt.push_back('{24'h800001, 24'h800000, 1'b0, 3'd7, 25'h0800002, 1'b1});
        vt.push_back('{24'h000003, 24'h800000, 1'b1, 3'd6, 25'h0000004, 1'b1});

        // Reset values
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
        in_mant = '0; in_tail = '0; in_sign = 1'b0; in_rnd = IEEE_near;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_result", 64'(out_result), 64'd0);
        chk("rst_carry", 64'(out_carry), 64'd0);
        chk("rst_inexact", 64'(out_inexact), 64'd0);
        chk("rst_sign", 64'(out_sign), 64'd0);
        chk("rst_cnt", 64'(inexact_cnt), 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Latency: accepted on one edge, visible after the next
        send_m(24'h000010, 24'h000000, 1'b0, 3'd0);
        idle();
        @(negedge clk);
        chk("latency_early", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("latency_valid", 64'(out_valid), 64'd1);
        drain();

        foreach (vt[i]) begin
            exp_t e;
            e.res = vt[i].res; e.inx = vt[i].inx; e.sgn = vt[i].sign;
            send(vt[i].mant, vt[i].tail, vt[i].sign, vt[i].rnd, e);
        end
        idle();
        drain();

        for (int i = 0; i < 24; i++)
            send_m(24'($urandom), 24'($urandom), 1'($urandom), 3'($urandom_range(0, 7)));
        idle();
        drain();

        // Backpressure: 4 back-to-back with out_ready low for 3 cycles
        out_ready = 1'b0;
        base = acc_cnt;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    send_m(24'h200000 + 24'(i), 24'h400001, 1'b0, 3'd0);
                idle();
            end
            begin
                for (int i = 0; i < 50 && acc_cnt == base; i++) @(posedge clk);
                repeat (3) @(posedge clk);
                #1;
                chk("bp_in_ready", 64'(in_ready), 64'd0);
                chk("bp_accepts", 64'(acc_cnt - base), 64'd2);
                out_ready = 1'b1;
            end
        join
        drain();

        // Counter: clear, exact results don't count, then saturate
        cnt_clr = 1'b1;
        @(posedge clk); #1 cnt_clr = 1'b0;
        @(negedge clk);
        chk("cnt_clear", 64'(inexact_cnt), 64'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++)
            send_m(24'($urandom), 24'h000000, 1'b0, 3'd5);
        idle();
        drain();
        chk("cnt_exact", 64'(inexact_cnt), 64'd0);
        for (int i = 0; i < 5; i++)
            send_m(24'($urandom_range(0, 24'h7FFFFF)), 24'h000001, 1'b0, 3'd1);
        idle();
        drain();
        chk("cnt_5", 64'(inexact_cnt), 64'd5);
        for (int i = 0; i < 15; i++)
            send_m(24'($urandom_range(0, 24'h7FFFFF)), 24'h000001, 1'b1, 3'd1);
        idle();
        drain();
        chk("cnt_sat", 64'(inexact_cnt), 64'd15);

        // Clear coincident with an inexact transfer
        out_ready = 1'b0;
        send_m(24'h000100, 24'h000003, 1'b0, 3'd5);
        idle();
        for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
        @(posedge clk); #1;
        out_ready = 1'b1;
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        @(negedge clk);
        chk("cnt_clr_wins", 64'(inexact_cnt), 64'd0);
        drain();

        // Mid-stream reset with two transactions in flight
        out_ready = 1'b0;
        send_m(24'h0000AA, 24'h800000, 1'b0, 3'd5);
        send_m(24'h0000BB, 24'h800000, 1'b0, 3'd5);
        idle();
        rst = 1'b1;
        q.delete();
        #1;
        chk("mrst_out_valid", 64'(out_valid), 64'd0);
        chk("mrst_in_ready", 64'(in_ready), 64'd1);
        chk("mrst_cnt", 64'(inexact_cnt), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("mrst_no_out", 64'(out_valid), 64'd0);
        end
        @(posedge clk); #1;
        send_m(24'h000055, 24'h000000, 1'b1, 3'd0);
        idle();
        drain();
    endtask

    initial begin
        fork
            run_tests();
            monitor();
            begin
                #200us;
                chk("global_timeout", 64'd0, 64'd1);
            end
        join_any
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
